// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data load/store requesters.
// Round-robin grant on ties, per-access timeout watchdog, misaligned accesses rejected without a memory cycle.
module mem_port_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic        if_err,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_f3,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic        d_err,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [2:0]  mem_f3,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  // Handshake: a requester holds req and its payload stable until its one-cycle
  // ack; the memory holds mem_req and fields stable until its one-cycle mem_ack.
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] IF_BUSY = 2'd1;
  localparam logic [1:0] D_BUSY  = 2'd2;
  localparam logic [1:0] ERR_RSP = 2'd3;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state;
  logic             owner;
  logic             last;
  logic [CNT_W-1:0] cnt;

  logic        grant_any;
  logic        win;
  logic        d_misaligned;
  logic        win_misaligned;
  logic        in_busy;
  logic        expire;
  logic        done;
  logic        rsp;
  logic        rsp_err;
  logic [31:0] rsp_rdata;

  always_comb begin
    grant_any = if_req | d_req;
    // Data wins when alone, or on a tie when fetch had the previous grant.
    win = d_req & (~if_req | (last == OWN_IF));
    d_misaligned = d_f3[1] ? (d_addr[1:0] != 2'b00) : (d_f3[0] & d_addr[0]);
    win_misaligned = win ? d_misaligned : (if_addr[1:0] != 2'b00);

    in_busy = (state == IF_BUSY) || (state == D_BUSY);
    expire  = in_busy && (cnt == CNT_LAST);
    // A completion in the expiry cycle beats the timeout.
    done      = in_busy && (mem_ack || expire);
    rsp       = done || (state == ERR_RSP);
    rsp_err   = (state == ERR_RSP) || (in_busy && !mem_ack && expire);
    rsp_rdata = (in_busy && mem_ack && !mem_we) ? mem_rdata : 32'd0;

    if_ack   = rsp && (owner == OWN_IF);
    if_err   = rsp_err && (owner == OWN_IF);
    if_rdata = (owner == OWN_IF) ? rsp_rdata : 32'd0;
    d_ack    = rsp && (owner == OWN_D);
    d_err    = rsp_err && (owner == OWN_D);
    d_rdata  = (owner == OWN_D) ? rsp_rdata : 32'd0;

    busy      = (state != IDLE);
    dbg_state = state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= OWN_IF;
      last      <= OWN_D;
      cnt       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_f3    <= 3'b000;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            owner <= win;
            last  <= win;
            cnt   <= '0;
            if (win_misaligned) begin
              state <= ERR_RSP;
            end else begin
              state     <= win ? D_BUSY : IF_BUSY;
              mem_req   <= 1'b1;
              mem_we    <= win & d_we;
              mem_f3    <= win ? d_f3 : 3'b010;
              mem_addr  <= win ? d_addr : if_addr;
              mem_wdata <= win ? d_wdata : 32'd0;
            end
          end
        end
        IF_BUSY, D_BUSY: begin
          if (done) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            cnt     <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, tie alternation, store, misalignment,
// timeout, and reset during an access. Inputs change and outputs are checked at negedge.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic        if_err;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [2:0]  d_f3;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic        d_err;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [2:0]  mem_f3;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        busy;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_mis = 0;
  logic [31:0] exp_q[$];

  mem_port_arbiter #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_err(if_err), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_f3(d_f3), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_f3(mem_f3), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    if_req = 1'b0; if_addr = 32'd0;
    d_req = 1'b0; d_we = 1'b0; d_f3 = 3'b000; d_addr = 32'd0; d_wdata = 32'd0;
    mem_ack = 1'b0; mem_rdata = 32'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Leaves the caller at the negedge of the first mem_req cycle.
  task automatic wait_mem_req(input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      if (mem_req) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq(tag, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    #1;
    check_eq("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'd0);
    check_eq("rst_acks", {30'd0, if_ack, d_ack}, 32'd0);
    check_eq("rst_state", {30'd0, dbg_state}, 32'd0);
    rst = 1'b0;

    // single fetch, memory answers in the third mem_req cycle
    @(negedge clk); if_req = 1'b1; if_addr = 32'h10; #1;
    check_eq("f_c0_busy", {31'd0, busy}, 32'd0);
    @(negedge clk); #1;
    check_eq("f_c1_mem_req", {31'd0, mem_req}, 32'd1);
    check_eq("f_c1_mem_addr", mem_addr, 32'h10);
    check_eq("f_c1_mem_f3", {29'd0, mem_f3}, 32'd2);
    check_eq("f_c1_mem_we", {31'd0, mem_we}, 32'd0);
    check_eq("f_c1_mem_wdata", mem_wdata, 32'd0);
    check_eq("f_c1_if_ack", {31'd0, if_ack}, 32'd0);
    check_eq("f_c1_state", {30'd0, dbg_state}, 32'd1);
    @(negedge clk); #1;
    check_eq("f_c2_mem_req", {31'd0, mem_req}, 32'd1);
    @(negedge clk); mem_ack = 1'b1; mem_rdata = 32'h00A00093; #1;
    check_eq("f_c3_mem_req", {31'd0, mem_req}, 32'd1);
    check_eq("f_c3_if_ack", {31'd0, if_ack}, 32'd1);
    check_eq("f_c3_if_err", {31'd0, if_err}, 32'd0);
    check_eq("f_c3_if_rdata", if_rdata, 32'h00A00093);
    check_eq("f_c3_d_ack", {31'd0, d_ack}, 32'd0);
    check_eq("f_c3_d_rdata", d_rdata, 32'd0);
    @(negedge clk); mem_ack = 1'b0; mem_rdata = 32'd0; if_req = 1'b0; #1;
    check_eq("f_c4_busy", {31'd0, busy}, 32'd0);
    check_eq("f_c4_mem_req", {31'd0, mem_req}, 32'd0);
    check_eq("f_c4_if_ack", {31'd0, if_ack}, 32'd0);

    // tie after reset: fetch first, then alternation while both stay high
    do_reset();
    for (int i = 0; i < 6; i++) exp_q.push_back((i % 2 == 0) ? 32'h100 : 32'h200);
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100;
    d_req = 1'b1; d_we = 1'b0; d_f3 = 3'b010; d_addr = 32'h200;
    for (int i = 0; i < 6; i++) begin
      logic [31:0] exp_addr;
      logic [31:0] rd;
      wait_mem_req("tie_mem_req");
      exp_addr = exp_q.pop_front();
      check_eq("tie_mem_addr", mem_addr, exp_addr);
      rd = 32'h1000 + 32'(i);
      mem_ack = 1'b1; mem_rdata = rd; #1;
      check_eq("tie_if_ack", {31'd0, if_ack}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check_eq("tie_d_ack", {31'd0, d_ack}, (i % 2 == 1) ? 32'd1 : 32'd0);
      check_eq("tie_if_rdata", if_rdata, (i % 2 == 0) ? rd : 32'd0);
      check_eq("tie_d_rdata", d_rdata, (i % 2 == 1) ? rd : 32'd0);
      @(negedge clk); mem_ack = 1'b0; mem_rdata = 32'd0; #1;
      check_eq("tie_turnaround", {31'd0, mem_req}, 32'd0);
      if (i == 5) begin
        if_req = 1'b0;
        d_req = 1'b0;
      end
    end
    @(negedge clk); #1;
    check_eq("tie_idle", {31'd0, busy}, 32'd0);

    // halfword store, second mem_req cycle completes
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_f3 = 3'b001; d_addr = 32'h22; d_wdata = 32'hBEEF;
    wait_mem_req("st_mem_req");
    check_eq("st_mem_we", {31'd0, mem_we}, 32'd1);
    check_eq("st_mem_f3", {29'd0, mem_f3}, 32'd1);
    check_eq("st_mem_addr", mem_addr, 32'h22);
    check_eq("st_mem_wdata", mem_wdata, 32'hBEEF);
    check_eq("st_no_ack", {31'd0, d_ack}, 32'd0);
    @(negedge clk); mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF; #1;
    check_eq("st_d_ack", {31'd0, d_ack}, 32'd1);
    check_eq("st_d_err", {31'd0, d_err}, 32'd0);
    check_eq("st_d_rdata", d_rdata, 32'd0);
    @(negedge clk); mem_ack = 1'b0; mem_rdata = 32'd0; d_req = 1'b0; d_we = 1'b0; #1;

    // misaligned word load
    @(negedge clk); d_req = 1'b1; d_f3 = 3'b010; d_addr = 32'h41; #1;
    @(negedge clk); #1;
    check_eq("mis_w_mem_req", {31'd0, mem_req}, 32'd0);
    check_eq("mis_w_d_ack", {31'd0, d_ack}, 32'd1);
    check_eq("mis_w_d_err", {31'd0, d_err}, 32'd1);
    check_eq("mis_w_state", {30'd0, dbg_state}, 32'd3);
    @(negedge clk); d_req = 1'b0; #1;
    check_eq("mis_w_after_ack", {31'd0, d_ack}, 32'd0);
    check_eq("mis_w_after_busy", {31'd0, busy}, 32'd0);

    // misaligned halfword load
    @(negedge clk); d_req = 1'b1; d_f3 = 3'b101; d_addr = 32'h23; #1;
    @(negedge clk); #1;
    check_eq("mis_h_mem_req", {31'd0, mem_req}, 32'd0);
    check_eq("mis_h_d_err", {31'd0, d_err}, 32'd1);
    @(negedge clk); d_req = 1'b0;

    // misaligned fetch
    @(negedge clk); if_req = 1'b1; if_addr = 32'h6; #1;
    @(negedge clk); #1;
    check_eq("mis_f_mem_req", {31'd0, mem_req}, 32'd0);
    check_eq("mis_f_if_ack", {31'd0, if_ack}, 32'd1);
    check_eq("mis_f_if_err", {31'd0, if_err}, 32'd1);
    check_eq("mis_f_if_rdata", if_rdata, 32'd0);
    @(negedge clk); if_req = 1'b0;

    // byte at an odd address is aligned
    @(negedge clk); d_req = 1'b1; d_f3 = 3'b000; d_addr = 32'h43;
    wait_mem_req("byte_mem_req");
    check_eq("byte_mem_addr", mem_addr, 32'h43);
    mem_ack = 1'b1; mem_rdata = 32'h7F; #1;
    check_eq("byte_d_err", {31'd0, d_err}, 32'd0);
    check_eq("byte_d_rdata", d_rdata, 32'h7F);
    @(negedge clk); mem_ack = 1'b0; mem_rdata = 32'd0; d_req = 1'b0;

    // timeout: no mem_ack, then mem_ack exactly in the expiry cycle
    for (int run = 0; run < 2; run++) begin
      @(negedge clk); if_req = 1'b1; if_addr = 32'h30;
      wait_mem_req("to_mem_req");
      check_eq("to_c1_ack", {31'd0, if_ack}, 32'd0);
      for (int k = 2; k <= 15; k++) begin
        @(negedge clk); #1;
        check_eq("to_early_ack", {31'd0, if_ack}, 32'd0);
      end
      @(negedge clk);
      if (run == 1) begin
        mem_ack = 1'b1; mem_rdata = 32'h5A5A;
      end
      #1;
      check_eq("to_c16_mem_req", {31'd0, mem_req}, 32'd1);
      check_eq("to_c16_ack", {31'd0, if_ack}, 32'd1);
      check_eq("to_c16_err", {31'd0, if_err}, (run == 0) ? 32'd1 : 32'd0);
      check_eq("to_c16_rdata", if_rdata, (run == 0) ? 32'd0 : 32'h5A5A);
      @(negedge clk); mem_ack = 1'b0; mem_rdata = 32'd0; if_req = 1'b0; #1;
      check_eq("to_after_mem_req", {31'd0, mem_req}, 32'd0);
      check_eq("to_after_busy", {31'd0, busy}, 32'd0);
    end

    // reset during D_BUSY cycle 2, then a late mem_ack
    @(negedge clk); d_req = 1'b1; d_we = 1'b0; d_f3 = 3'b010; d_addr = 32'h80;
    wait_mem_req("rm_mem_req");
    check_eq("rm_state", {30'd0, dbg_state}, 32'd2);
    @(negedge clk); rst = 1'b1; #1;
    check_eq("rm_c2_ack", {31'd0, d_ack}, 32'd0);
    @(negedge clk); rst = 1'b0; d_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h1234; #1;
    check_eq("rm_mem_req", {31'd0, mem_req}, 32'd0);
    check_eq("rm_busy", {31'd0, busy}, 32'd0);
    check_eq("rm_late_d_ack", {31'd0, d_ack}, 32'd0);
    check_eq("rm_late_if_ack", {31'd0, if_ack}, 32'd0);
    check_eq("rm_late_d_rdata", d_rdata, 32'd0);
    @(negedge clk); mem_ack = 1'b0; mem_rdata = 32'd0; #1;
    check_eq("rm_still_idle", {31'd0, busy}, 32'd0);
    check_eq("rm_no_mem_req", {31'd0, mem_req}, 32'd0);

    if (exp_q.size() != 0) begin
      n_mis++;
      $display("FAIL exp_q_drain: got %0d entries expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified memory port between the instruction-fetch requester and the data (load/store) requester.
- Used in the multi-cycle build of the RV32 core, where instruction memory and data memory collapse into one memory.
- Handshakes use req/ack. A registered grant FSM with round-robin tie-break drives the memory port.
- Also provides a per-access timeout watchdog and a misalignment check that returns an error without touching memory.

Parameters:
TIMEOUT, 16, cycles mem_req may stay high without mem_ack before an error response (2..31)
CNT_W, 5, timeout counter width; TIMEOUT < 2**CNT_W

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
if_req  in  1  fetch request; held high with stable if_addr until if_ack
if_addr  in  32  fetch byte address
if_ack  out  1  one-cycle fetch completion
if_err  out  1  valid with if_ack; 1 = misaligned or timeout
if_rdata  out  32  fetched word, valid with if_ack
d_req  in  1  data request; held with stable payload until d_ack
d_we  in  1  1 = store, 0 = load
d_f3  in  3  funct3 size code (000/100 byte, 001/101 half, 010 word)
d_addr  in  32  data byte address
d_wdata  in  32  store data
d_ack  out  1  one-cycle data completion
d_err  out  1  valid with d_ack
d_rdata  out  32  load data, valid with d_ack
mem_req  out  1  memory access strobe, registered
mem_we  out  1  registered
mem_f3  out  3  registered; 010 for fetches
mem_addr  out  32  registered
mem_wdata  out  32  registered; 0 for fetches
mem_ack  in  1  memory completion, one cycle
mem_rdata  in  32  valid with mem_ack
busy  out  1  state != IDLE

Behaviour:
- States: IDLE, IF_BUSY, D_BUSY, ERR_RSP. Register `owner` (IF/D) records the current grant. Register `last` records the previous grant.
- Reset: state=IDLE, all mem_* outputs=0, counter=0, last=D (first tie goes to fetch), owner=IF. All acks, errs and rdata outputs are 0.
- Arbitration happens in IDLE only:
  - Only one req high → grant it.
  - Both high → grant the requester != last.
  - On grant: last <= winner, owner <= winner.
- Misalignment check applies to the winner's address and size:
  - fetch: if_addr[1:0]!=0
  - half: d_addr[0]
  - word: d_addr[1:0]!=0
  - Misaligned → next state ERR_RSP. mem_req stays 0.
  - Aligned → next state IF_BUSY/D_BUSY. On the same edge, mem_req<=1 and the mem_* fields are latched from the winner.
  - Latency: req high at cycle 0 → mem_req high at cycle 1.
- IF_BUSY/D_BUSY:
  - mem_req held high, fields held stable. Counter increments each cycle.
  - mem_ack=1 → owner ack=1 combinationally in that cycle, err=0, rdata=mem_rdata (0 for stores).
  - Next edge after mem_ack: mem_req<=0, counter<=0, state<=IDLE.
- Timeout: counter reaches TIMEOUT-1 with mem_ack=0 → owner ack=1, err=1, rdata=0 that cycle. Next edge returns to IDLE with mem_req<=0.
  - mem_ack in the same cycle as expiry wins: err=0.
- ERR_RSP lasts one cycle: owner ack=1, err=1, rdata=0, then IDLE.
- Non-owner ack/err/rdata outputs are always 0.
- mem_ack while in IDLE or ERR_RSP is ignored.
- Requesters drop req on the edge after their ack. A req still high in IDLE is treated as a new request.
- Minimum turnaround is 1 IDLE cycle between consecutive accesses.
- A requester that changes its payload mid-access gets undefined results. There is no check; verification asserts stability.
- rst mid-access: next edge forces the reset values. The pending requester gets no ack and must reissue its request.

Test Plan:
- Single fetch: if_req=1, if_addr=0x10, mem_ack at cycle 3 with rdata=0x00A00093 → mem_req=1 in cycles 1–3, mem_addr=0x10, mem_f3=010; if_ack=1, if_err=0, if_rdata=0x00A00093 in cycle 3; busy=0 in cycle 4.
- Tie after reset: if_req and d_req both high with 1-cycle memory → fetch granted first, data second. Then hold both high for 4 more accesses → grants alternate IF, D, IF, D.
- Store: d_we=1, d_f3=001, d_addr=0x22, d_wdata=0xBEEF → mem_we=1, mem_f3=001, mem_wdata=0xBEEF, d_ack on mem_ack, d_rdata=0.
- Misaligned: d_f3=010, d_addr=0x41 → mem_req never rises; d_ack=1, d_err=1 in cycle 1. Fetch at if_addr=0x6 → if_err=1.
- Timeout: TIMEOUT=16, mem_ack never asserted → if_ack=if_err=1 in the 16th mem_req cycle, mem_req=0 after. Repeat with mem_ack in exactly that cycle → if_err=0.
- Reset mid-access: rst=1 during D_BUSY cycle 2 → mem_req=0, busy=0 next cycle, no d_ack. A late mem_ack after reset produces no ack.
